// File: rtl/switch_throw_sequencer.sv
// switch_throw_sequencer: serialises point-motor throws, one coil pulse plus settle gap per switch
module switch_throw_sequencer #(
  parameter int NUM_SWITCHES = 12,
  parameter int PULSE_CYCLES = 5000000,
  parameter int GAP_CYCLES   = 2500000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NUM_SWITCHES-1:0] target,
  input  logic [NUM_SWITCHES-1:0] polarity,
  input  logic [NUM_SWITCHES-1:0] enable,
  output logic [NUM_SWITCHES-1:0] coil_a,
  output logic [NUM_SWITCHES-1:0] coil_b,
  output logic [NUM_SWITCHES-1:0] position,
  output logic                    busy,
  output logic                    aligned
);
  localparam int MX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;
  localparam int SW = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           sel_q, sel_d, ptr_q, ptr_d, pick, idx;
  logic                    dir_q, dir_d, pol_q, pol_d, aligned_q, aligned_d, hit;
  logic [NUM_SWITCHES-1:0] known_q, known_d, pos_q, pos_d, pending, sel_oh;
  assign pending  = enable & (~known_q | (target ^ pos_q));
  assign sel_oh   = NUM_SWITCHES'(1) << sel_q;
  assign coil_a   = (state_q == PULSE && !(dir_q ^ pol_q)) ? sel_oh : '0;
  assign coil_b   = (state_q == PULSE && (dir_q ^ pol_q)) ? sel_oh : '0;
  assign position = pos_q;
  assign busy     = state_q != IDLE;
  assign aligned  = aligned_q;
  // first pending switch strictly after the pointer, wrapping; lower loop offsets win
  always_comb begin
    pick = '0;
    idx  = '0;
    hit  = |pending;
    for (int i = NUM_SWITCHES; i >= 1; i--) begin
      idx = SW'((int'(ptr_q) + i) % NUM_SWITCHES);
      pick = pending[idx] ? idx : pick;
    end
  end
  // throw sequencing: latch the choice in IDLE, count the pulse, then the settle gap
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    pol_d     = pol_q;
    ptr_d     = ptr_q;
    known_d   = known_q;
    pos_d     = pos_q;
    aligned_d = (state_q == IDLE) && (pending == '0);
    case (state_q)
      IDLE: if (hit) begin
        sel_d   = pick;
        dir_d   = target[pick];
        pol_d   = polarity[pick];
        ptr_d   = pick;
        cnt_d   = CW'(PULSE_CYCLES - 1);
        state_d = PULSE;
      end
      PULSE: if (cnt_q == '0) begin
        pos_d[sel_q]   = dir_q;
        known_d[sel_q] = 1'b1;
        cnt_d          = CW'(GAP_CYCLES - 1);
        state_d        = GAP;
      end else cnt_d = cnt_q - 1'b1;
      GAP: if (cnt_q == '0) state_d = IDLE;
      else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset drops the coils immediately via the state decode
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      dir_q     <= 1'b0;
      pol_q     <= 1'b0;
      ptr_q     <= SW'(NUM_SWITCHES - 1);
      known_q   <= '0;
      pos_q     <= '0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dir_q     <= dir_d;
      pol_q     <= pol_d;
      ptr_q     <= ptr_d;
      known_q   <= known_d;
      pos_q     <= pos_d;
      aligned_q <= aligned_d;
    end
  end
endmodule

// File: tb/tb_switch_throw_sequencer.sv
// tb_switch_throw_sequencer: directed plan plus random traffic against a throw-timeline model
module tb_switch_throw_sequencer;
  localparam int N = 12;
  localparam int P = 4;
  localparam int G = 2;
  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic [N-1:0] target, polarity, enable;
  logic [N-1:0] coil_a, coil_b, position;
  logic         busy, aligned;
  int           pass_cnt = 0;
  int           tot_cnt  = 0;
  int           t, m_ptr, m_sel;
  logic         m_dir, m_pol, m_al, found;
  logic [N-1:0] m_pos, m_known, pend, ea, eb, one;
  switch_throw_sequencer #(.NUM_SWITCHES(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .target(target), .polarity(polarity), .enable(enable),
    .coil_a(coil_a), .coil_b(coil_b), .position(position), .busy(busy), .aligned(aligned)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask
  // model: t is the cycle index within the current throw (-1 when idle)
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      t = -1; m_pos = '0; m_known = '0; m_ptr = N - 1; m_al = 1'b0; m_sel = 0; m_dir = 0; m_pol = 0;
    end else begin
      pend = enable & (~m_known | (target ^ m_pos));
      m_al = (t < 0) && (pend == '0);
      if (t < 0) begin
        if (pend != '0) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++)
            if (!found && pend[(m_ptr + k) % N]) begin found = 1'b1; m_sel = (m_ptr + k) % N; end
          m_dir = target[m_sel]; m_pol = polarity[m_sel]; m_ptr = m_sel; t = 0;
        end
      end else begin
        t++;
        if (t == P) begin m_pos[m_sel] = m_dir; m_known[m_sel] = 1'b1; end
        if (t == P + G) t = -1;
      end
    end
  end
  // every-cycle comparison away from the active edge
  always @(negedge CLOCK_50) begin
    one = 1;
    ea = (t >= 0 && t < P && !(m_dir ^ m_pol)) ? one << m_sel : '0;
    eb = (t >= 0 && t < P && (m_dir ^ m_pol)) ? one << m_sel : '0;
    chk("outputs", {coil_a, coil_b, position, busy, aligned}, {ea, eb, m_pos, t >= 0, m_al});
    chk("one_coil", 64'($countones({coil_a, coil_b}) <= 1), 64'd1);
  end
  initial begin
    reset = 1'b1; target = '0; polarity = '0; enable = '1;
    step(2);
    reset = 1'b0;
    step(1);  chk("home_first", coil_a, 12'h001);
    step(7);  chk("home_second", coil_a, 12'h002);
    step(76); chk("home_not_yet_aligned", aligned, 0);
    step(1);  chk("home_aligned", {aligned, position}, {1'b1, 12'h000});
    target[3] = 1'b1; target[9] = 1'b1;
    step(1);  chk("two_first", coil_b, 12'h008);
    step(7);  chk("two_second", {coil_b, aligned}, {12'h200, 1'b0});
    step(8);  chk("two_done", {aligned, position}, {1'b1, 12'h208});
    polarity[5] = 1'b1; target[5] = 1'b1;
    step(1);  chk("pol_coil", {coil_a, coil_b}, {12'h020, 12'h000});
    step(7);  chk("pol_pos", position, 12'h228);
    step(1);
    target[2] = 1'b1;
    step(1);  chk("rev_start", coil_b, 12'h004);
    step(1);  target[2] = 1'b0;
    step(2);  chk("rev_held", coil_b, 12'h004);
    step(1);  chk("rev_end", {coil_b, position}, {12'h000, 12'h22c});
    step(3);  chk("rev_back", coil_a, 12'h004);
    step(8);  chk("rev_done", {aligned, position}, {1'b1, 12'h228});
    target[7] = 1'b1;
    step(1);  chk("rst_coil", coil_b, 12'h080);
    step(1);
    reset = 1'b1;
    #1;       chk("rst_async", {coil_a, coil_b, position, busy, aligned}, 38'd0);
    step(2);
    target = 12'h010; polarity = '0; enable = 12'hfef;
    reset = 1'b0;
    step(1);  chk("rehome_first", coil_a, 12'h001);
    step(90); chk("disabled_aligned", {aligned, position}, {1'b1, 12'h000});
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(7) == 0) target[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(39) == 0) polarity[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(59) == 0) enable[$urandom_range(N - 1)] ^= 1'b1;
      if ($urandom_range(499) == 0) begin
        reset = 1'b1;
        step($urandom_range(2, 1));
        reset = 1'b0;
      end
    end
    step(2);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/switch_throw_sequencer.md
Name: switch_throw_sequencer

Overview:
- Sits between the route-interlocking logic (12 per-switch "diverging" request lines) and the point-motor drivers on GPIO.
- Motor power supply handles one coil at a time, so the block serialises throws: one fixed-length coil pulse, then a settle gap, then the next switch.
- Tracks the last commanded position of every switch.
- Reports when all enabled switches match their requested positions, so signals may clear.

Parameters:
- NUM_SWITCHES, 12, number of point motors served.
- PULSE_CYCLES, 5000000, coil energise time in clock cycles (100 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 2500000, de-energised settle time between throws; must be >= 1.

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- reset input 1: asynchronous, active-high reset.
- target input NUM_SWITCHES: requested position per switch (1 = diverging, 0 = normal), from interlocking.
- polarity input NUM_SWITCHES: per-switch wiring inversion; 1 swaps which coil throws diverging.
- enable input NUM_SWITCHES: per-switch service enable. A disabled switch is never driven and counts as aligned.
- coil_a output NUM_SWITCHES: "normal" coil drive, active-high.
- coil_b output NUM_SWITCHES: "reverse" coil drive, active-high.
- position output NUM_SWITCHES: last commanded position per switch.
- busy output 1: a throw (PULSE or GAP) is in progress.
- aligned output 1: all enabled switches are known and match target.

Behaviour:
- Reset values, applied immediately when reset rises:
  - coil_a = 0, coil_b = 0, position = 0, busy = 0, aligned = 0.
  - Internal known mask = 0; state = IDLE; round-robin pointer = NUM_SWITCHES-1.
- pending = enable & (~known | (target ^ position)). After reset, every enabled switch is thrown once (homing pass) because its real position is unknown.
- FSM states: IDLE, PULSE, GAP.
- IDLE:
  - If pending != 0, select the first pending index searching upward from pointer+1, wrapping modulo NUM_SWITCHES.
  - On that edge, latch sel, dir = target[sel] and pol = polarity[sel]. Set pointer = sel, load the counter, and go to PULSE.
  - The coil is high from that edge, so a coil rises 1 cycle after a pending condition is sampled.
- PULSE:
  - Exactly one coil bit is high: coil_b[sel] if (dir ^ pol) = 1, else coil_a[sel]. It is held for exactly PULSE_CYCLES cycles.
  - On the final cycle's edge: position[sel] = dir, known[sel] = 1, coils go to 0, then GAP.
- GAP:
  - All coils 0 for exactly GAP_CYCLES cycles, then IDLE.
  - Each throw therefore occupies 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- At most one coil bit across coil_a and coil_b is ever high. coil_a[i] and coil_b[i] are never high together.
- busy = 1 in PULSE and GAP, registered with the state.
- aligned is registered and updated every edge to (state == IDLE && pending == 0). It falls 1 cycle after a mismatching target is sampled in IDLE.
- Target, polarity or enable changes during PULSE/GAP do not affect the throw in progress; dir and pol stay latched. Pulses are never truncated, to avoid half-thrown points.
  - If target[sel] differs from the latched dir after the throw, the switch becomes pending again and is re-thrown in normal round-robin order.
- Round robin guarantees that a continuously pending enabled switch is served within NUM_SWITCHES throws.
- Reset asserted mid-PULSE: coils drop asynchronously that same instant, and all state returns to reset values. After release the homing pass restarts from switch 0.
- Counter widths are sized for max(PULSE_CYCLES, GAP_CYCLES). No wrap is permitted.

Test Plan (PULSE_CYCLES=4, GAP_CYCLES=2, NUM_SWITCHES=12):
- Homing pass: reset, enable=all 1s, target=0, polarity=0, release reset.
  - coil_a[0] high 4 cycles starting 1 cycle after release, then coil_a[1] 7 cycles later, and so on through switch 11.
  - aligned=1 on the edge after the last GAP, 84 cycles after the first coil; position=0.
- Two simultaneous requests: from aligned, set target[3]=1 and target[9]=1 in the same cycle.
  - coil_b[3] pulses 4 cycles; position[3]=1; coil_b[9] follows 7 cycles after coil_b[3] rose.
  - aligned stays 0 until both throws complete.
- Polarity inversion: polarity[5]=1, target[5] 0->1.
  - coil_a[5] pulses, not coil_b[5]; position[5]=1.
- Target reversal mid-pulse: target[2] 0->1, then back to 0 in the 2nd PULSE cycle.
  - coil_b[2] still completes 4 cycles; position[2]=1.
  - After GAP+IDLE, coil_a[2] pulses and position[2] returns to 0.
- Reset mid-pulse: assert reset during coil_b[7] high.
  - coil_b[7]=0 the same cycle with no clock edge needed; position=0, aligned=0.
  - After release, the homing pass starts at coil_a[0].
- Disabled switch: enable[4]=0 with target[4]=1.
  - coil_a[4]/coil_b[4] never assert; position[4] is unchanged.
  - aligned=1 once all other switches are homed.
